// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared types and constants for the iterative mult/div unit.
//   state_t   - FSM states (IDLE, CALC, FINISH)
//   OP_MULT / OP_DIV - encoding of the div_or_mult select
//   WIDTH_DEF - default operand width
package mult_div_pkg;

    localparam int   WIDTH_DEF = 32;
    localparam logic OP_MULT   = 1'b0;
    localparam logic OP_DIV    = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// div_step: one combinational restoring-division step on magnitudes.
//   rem_i  - partial remainder (always < dvsr_i)
//   dvsr_i - divisor magnitude
//   bit_i  - next dividend bit shifted into the remainder
//   rem_o  - new partial remainder
//   q_o    - quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvsr_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    assign shifted = {rem_i, bit_i};
    assign q_o     = (shifted >= {1'b0, dvsr_i});
    // When the subtraction succeeds the difference is below the divisor,
    // so the low WIDTH bits of the modular difference are exact.
    assign diff    = shifted[WIDTH-1:0] - dvsr_i;
    assign rem_o   = q_o ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed WIDTH x WIDTH multiplier (radix-2 Booth)
// and divider (restoring, on magnitudes with sign fix-up).
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   div_control         - start request, sampled only in IDLE
//   div_or_mult         - 1 = DIV, 0 = MULT, sampled with start
//   a_in, b_in          - multiplicand/dividend, multiplier/divisor
//   hi_out, lo_out      - product hi/lo, or remainder/quotient
//   busy                - operation in progress
//   done                - one-cycle completion pulse
//   div_zero            - divide-by-zero flag, held until next start
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_control,
    input  logic             div_or_mult,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    // MULT: {P_hi, P_lo, q-1}.  DIV: {remainder, dividend/quotient, unused}.
    logic [2*WIDTH:0]   acc_q;
    logic [WIDTH-1:0]   mcand_q;    // multiplicand, or divisor magnitude
    logic               op_q, qneg_q, rneg_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q, dz_q;

    // Booth step: the add/sub is done one bit wider so the arithmetic shift
    // keeps the true sign even when the multiplicand is the most negative value.
    logic [WIDTH:0]     p_ext, m_ext, booth_sum;
    logic [2*WIDTH:0]   booth_nxt;

    assign p_ext = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    assign m_ext = {mcand_q[WIDTH-1], mcand_q};

    always_comb begin
        booth_sum = p_ext;
        case (acc_q[1:0])
            2'b01:   booth_sum = p_ext + m_ext;
            2'b10:   booth_sum = p_ext - m_ext;
            default: booth_sum = p_ext;
        endcase
    end

    // Dropping the extra sum LSB into P_lo and P_lo[0] into q-1 is the shift.
    assign booth_nxt = {booth_sum, acc_q[WIDTH:1]};

    // Restoring step: MSB of the dividend register feeds the remainder,
    // the quotient bit enters at its LSB.
    logic [WIDTH-1:0]   rem_nxt;
    logic               qbit;
    logic [2*WIDTH:0]   div_nxt, acc_nxt;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i  (acc_q[2*WIDTH:WIDTH+1]),
        .dvsr_i (mcand_q),
        .bit_i  (acc_q[WIDTH]),
        .rem_o  (rem_nxt),
        .q_o    (qbit)
    );

    assign div_nxt = {rem_nxt, acc_q[WIDTH-1:1], qbit, 1'b0};
    assign acc_nxt = (op_q == OP_DIV) ? div_nxt : booth_nxt;

    // Final results taken from the last step's next value.
    logic [WIDTH-1:0] quot, rem, res_hi, res_lo;
    assign quot   = acc_nxt[WIDTH:1];
    assign rem    = acc_nxt[2*WIDTH:WIDTH+1];
    assign res_lo = (op_q == OP_DIV) ? (qneg_q ? -quot : quot) : acc_nxt[WIDTH:1];
    assign res_hi = (op_q == OP_DIV) ? (rneg_q ? -rem  : rem)  : acc_nxt[2*WIDTH:WIDTH+1];

    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = a_in[WIDTH-1] ? -a_in : a_in;
    assign b_mag = b_in[WIDTH-1] ? -b_in : b_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            op_q    <= OP_MULT;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (div_control) begin
                        op_q <= div_or_mult;
                        dz_q <= 1'b0;
                        if (div_or_mult == OP_DIV && b_in == '0) begin
                            // Results are left untouched; only the flag reports it.
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            if (div_or_mult == OP_DIV) begin
                                acc_q   <= {{WIDTH{1'b0}}, a_mag, 1'b0};
                                mcand_q <= b_mag;
                            end else begin
                                acc_q   <= {{WIDTH{1'b0}}, b_in, 1'b0};
                                mcand_q <= a_in;
                            end
                            qneg_q  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            rneg_q  <= a_in[WIDTH-1];
                            cnt_q   <= CNT_W'(WIDTH - 1);
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against a
// plain-arithmetic reference (64-bit signed multiply, truncating divide).
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset, div_control, div_or_mult;
    logic [W-1:0] a_in, b_in, hi_out, lo_out;
    logic         busy, done, div_zero;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_hi = '0, exp_lo = '0;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .div_control (div_control),
        .div_or_mult (div_or_mult),
        .a_in        (a_in),
        .b_in        (b_in),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: exact signed product, or C-style truncating quotient/remainder.
    function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  inout logic [W-1:0] hi, inout logic [W-1:0] lo, output logic dz);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        if (op == 1'b0) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == '0) begin
            dz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endfunction

    // Issues one start and checks busy/done timing, result stability and result.
    // pulse_at >= 0 re-raises div_control in that CALC cycle with other operands.
    task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int pulse_at);
        logic [W-1:0] prev_hi, prev_lo;
        logic         dz_e;
        prev_hi = exp_hi;
        prev_lo = exp_lo;
        model(op, a, b, exp_hi, exp_lo, dz_e);
        @(negedge clock);
        div_control = 1'b1; div_or_mult = op; a_in = a; b_in = b;
        @(negedge clock);
        div_control = 1'b0; a_in = $urandom; b_in = $urandom;
        if (dz_e) begin
            check({tag, " dz busy/done"}, {62'd0, busy, done}, 64'd1);
            check({tag, " dz flag"}, {63'd0, div_zero}, 64'd1);
            check({tag, " dz result held"}, {hi_out, lo_out}, {prev_hi, prev_lo});
            @(negedge clock);
            check({tag, " dz done pulse"}, {63'd0, done}, 64'd0);
            return;
        end
        for (int i = 0; i < W; i++) begin
            if (i == pulse_at) begin
                div_control = 1'b1; div_or_mult = ~op; a_in = $urandom; b_in = $urandom;
            end else begin
                div_control = 1'b0;
            end
            check({tag, " calc busy/done"}, {62'd0, busy, done}, 64'd2);
            check({tag, " calc result stable"}, {hi_out, lo_out}, {prev_hi, prev_lo});
            @(negedge clock);
        end
        div_control = 1'b0;
        check({tag, " finish busy/done"}, {62'd0, busy, done}, 64'd1);
        check({tag, " result"}, {hi_out, lo_out}, {exp_hi, exp_lo});
        check({tag, " div_zero"}, {63'd0, div_zero}, 64'd0);
        @(negedge clock);
        check({tag, " done pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic seen_done;
        logic op;
        logic [W-1:0] ra, rb;
        reset = 1'b1; div_control = 1'b0; div_or_mult = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset outputs", {hi_out, lo_out}, 64'd0);
        check("reset flags", {61'd0, busy, done, div_zero}, 64'd0);

        run_op("mult 7x-3", 1'b0, 32'h7, 32'hFFFFFFFD, -1);
        run_op("mult min*min", 1'b0, 32'h80000000, 32'h80000000, -1);
        run_op("mult -1*-1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        run_op("div -7/2", 1'b1, 32'hFFFFFFF9, 32'h2, -1);
        run_op("div 7/-2", 1'b1, 32'h7, 32'hFFFFFFFE, -1);
        run_op("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, -1);
        run_op("div 0x451/0x20", 1'b1, 32'h451, 32'h20, -1);
        run_op("div 5/0", 1'b1, 32'h5, 32'h0, -1);
        run_op("mult after dz", 1'b0, 32'h9, 32'h9, -1);
        run_op("mult 3x4 ignored start", 1'b0, 32'h3, 32'h4, 9);

        // Reset during a divide: outputs clear, no done for the aborted op.
        @(negedge clock);
        div_control = 1'b1; div_or_mult = 1'b1; a_in = 32'd100; b_in = 32'd7;
        @(negedge clock);
        div_control = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("reset mid busy/done", {62'd0, busy, done}, 64'd0);
        check("reset mid result", {hi_out, lo_out}, 64'd0);
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen_done |= done;
        end
        check("no done after abort", {63'd0, seen_done}, 64'd0);
        run_op("div 100/7", 1'b1, 32'd100, 32'd7, -1);

        // div_control held high: start in FINISH ignored, next IDLE accepts.
        @(negedge clock);
        div_control = 1'b1; div_or_mult = 1'b0; a_in = 32'd5; b_in = 32'd6;
        @(negedge clock);
        a_in = 32'd9; b_in = 32'd10;
        for (int i = 0; i < W; i++) begin
            check("b2b first busy", {63'd0, busy}, 64'd1);
            @(negedge clock);
        end
        check("b2b first done", {63'd0, done}, 64'd1);
        check("b2b first result", {hi_out, lo_out}, 64'd30);
        @(negedge clock);
        check("b2b idle gap", {62'd0, busy, done}, 64'd0);
        @(negedge clock);
        check("b2b second accepted", {63'd0, busy}, 64'd1);
        div_control = 1'b0;
        repeat (W) @(negedge clock);
        check("b2b second done", {63'd0, done}, 64'd1);
        check("b2b second result", {hi_out, lo_out}, 64'd90);
        exp_hi = '0; exp_lo = 32'd90;
        @(negedge clock);

        for (int n = 0; n < 16; n++) begin
            op = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
            if (n % 3 == 0) rb = rb >> $urandom_range(0, 31);
            run_op("random", op, ra, rb, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
